// File: rtl/sap_1_controller_sequencer_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, control words,
// CON bit positions and the one-hot T-state encoding.
package sap_1_controller_sequencer_pkg;

    localparam int OP_W  = 4;
    localparam int CON_W = 12;

    // Opcodes (IR upper nibble)
    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    // Control words {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
    localparam logic [CON_W-1:0] CW_FETCH_T1 = 12'h5E3;
    localparam logic [CON_W-1:0] CW_FETCH_T2 = 12'hBE3;
    localparam logic [CON_W-1:0] CW_FETCH_T3 = 12'h263;
    localparam logic [CON_W-1:0] CW_LDA_T4   = 12'h1A3;
    localparam logic [CON_W-1:0] CW_LDA_T5   = 12'h2C3;
    localparam logic [CON_W-1:0] CW_ALU_T4   = 12'h1A3;
    localparam logic [CON_W-1:0] CW_ALU_T5   = 12'h2E1;
    localparam logic [CON_W-1:0] CW_ADD_T6   = 12'h3C7;
    localparam logic [CON_W-1:0] CW_SUB_T6   = 12'h3CF;
    localparam logic [CON_W-1:0] CW_OUT_T4   = 12'h3F2;
    localparam logic [CON_W-1:0] CW_NOP      = 12'h3E3;

    // CON bit indices
    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    // One-hot ring states
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    // True for opcodes the decoder does not know
    function automatic logic is_undefined_op(logic [OP_W-1:0] op);
        return !(op == OP_LDA || op == OP_ADD || op == OP_SUB ||
                 op == OP_OUT || op == OP_HLT);
    endfunction

endpackage

// File: rtl/sap_1_ring_counter.sv
// One-hot T1..T6 ring counter with advance and restart-to-T1 controls.
// Restart wins over Adv; an illegal state recovers to T1.
module sap_1_ring_counter
    import sap_1_controller_sequencer_pkg::*;
(
    input  logic       Clk,
    input  logic       Clr_n,
    input  logic       Adv,
    input  logic       Restart,
    output logic [5:0] T
);

    t_state_e state_q, state_d;

    // Next ring position: restart, hold, or rotate one step
    always_comb begin
        state_d = state_q;
        if (Restart) begin
            state_d = T1;
        end else if (Adv) begin
            case (state_q)
                T1:      state_d = T2;
                T2:      state_d = T3;
                T3:      state_d = T4;
                T4:      state_d = T5;
                T5:      state_d = T6;
                T6:      state_d = T1;
                default: state_d = T1;
            endcase
        end
    end

    // State register with synchronous active-low clear
    always_ff @(posedge Clk) begin
        if (!Clr_n) state_q <= T1;
        else        state_q <= state_d;
    end

    assign T = state_q;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller/sequencer: ring counter, opcode decoder, halt flag.
// Optional macro SAP_1_CTRL_VARIABLE_CYCLE_EN returns to T1 early when the
// remaining T states would only be NOP (LDA after T5, OUT/undefined after T4).
module sap_1_controller_sequencer
    import sap_1_controller_sequencer_pkg::*;
(
    input  logic             Clk,
    input  logic             Clr_n,
    input  logic [OP_W-1:0]  Opcode,
    output logic [CON_W-1:0] CON,
    output logic             Cp,
    output logic             Ep,
    output logic             Hlt,
    output logic [5:0]       T
);

    logic [5:0]       t;
    logic             halted_q;
    logic             hlt_at_t4;
    logic             adv;
    logic             restart;
    logic [CON_W-1:0] con_dec;

    sap_1_ring_counter u_ring (
        .Clk     (Clk),
        .Clr_n   (Clr_n),
        .Adv     (adv),
        .Restart (restart),
        .T       (t)
    );

    // Fresh HLT decode; once halted the flag alone holds the machine
    assign hlt_at_t4 = (t == T4) && (Opcode == OP_HLT) && !halted_q;
    assign adv       = !halted_q && !hlt_at_t4;

`ifdef SAP_1_CTRL_VARIABLE_CYCLE_EN
    assign restart = !halted_q &&
                     (((t == T5) && (Opcode == OP_LDA)) ||
                      ((t == T4) && ((Opcode == OP_OUT) || is_undefined_op(Opcode))));
`else
    assign restart = 1'b0;
`endif

    // Control-word decode from current T state and opcode
    always_comb begin
        con_dec = CW_NOP;
        case (t)
            T1: con_dec = CW_FETCH_T1;
            T2: con_dec = CW_FETCH_T2;
            T3: con_dec = CW_FETCH_T3;
            T4: begin
                case (Opcode)
                    OP_LDA:  con_dec = CW_LDA_T4;
                    OP_ADD:  con_dec = CW_ALU_T4;
                    OP_SUB:  con_dec = CW_ALU_T4;
                    OP_OUT:  con_dec = CW_OUT_T4;
                    default: con_dec = CW_NOP;
                endcase
            end
            T5: begin
                case (Opcode)
                    OP_LDA:  con_dec = CW_LDA_T5;
                    OP_ADD:  con_dec = CW_ALU_T5;
                    OP_SUB:  con_dec = CW_ALU_T5;
                    default: con_dec = CW_NOP;
                endcase
            end
            T6: begin
                case (Opcode)
                    OP_ADD:  con_dec = CW_ADD_T6;
                    OP_SUB:  con_dec = CW_SUB_T6;
                    default: con_dec = CW_NOP;
                endcase
            end
            default: con_dec = CW_NOP;
        endcase
    end

    // Halt flag: set on HLT in T4, cleared only by Clr_n
    always_ff @(posedge Clk) begin
        if (!Clr_n)         halted_q <= 1'b0;
        else if (hlt_at_t4) halted_q <= 1'b1;
    end

    assign CON = halted_q ? CW_NOP : con_dec;
    assign Cp  = CON[CON_CP];
    assign Ep  = CON[CON_EP];
    assign Hlt = halted_q | hlt_at_t4;
    assign T   = t;

endmodule
